// File: rtl/bouncing_square_painter_if.sv
// Pixel-side bundle between the timing generator, the square painter and the TMDS encoders.
// The master drives coordinates, timing and controls; the slave returns colour, delayed timing and status.
interface bouncing_square_painter_if #(
    parameter int COORD_BITS  = 10,
    parameter int COLOUR_BITS = 8
);
    logic [COORD_BITS-1:0]  i_sx;
    logic [COORD_BITS-1:0]  i_sy;
    logic                   i_hsync;
    logic                   i_vsync;
    logic                   i_de;
    logic                   i_nf;
    logic [1:0]             i_speed;
    logic                   i_pause;
    logic [COLOUR_BITS-1:0] o_red;
    logic [COLOUR_BITS-1:0] o_green;
    logic [COLOUR_BITS-1:0] o_blue;
    logic                   o_hsync;
    logic                   o_vsync;
    logic                   o_de;
    logic [7:0]             o_bounce_count;
    logic                   o_corner;

    modport master (
        output i_sx, i_sy, i_hsync, i_vsync, i_de, i_nf, i_speed, i_pause,
        input  o_red, o_green, o_blue, o_hsync, o_vsync, o_de, o_bounce_count, o_corner
    );

    modport slave (
        input  i_sx, i_sy, i_hsync, i_vsync, i_de, i_nf, i_speed, i_pause,
        output o_red, o_green, o_blue, o_hsync, o_vsync, o_de, o_bounce_count, o_corner
    );
endinterface

// File: rtl/bouncing_square_painter.sv
// Paints a bouncing filled square over a fixed background for the 480p HDMI path.
// Position moves once per new-frame strobe; the pixel path is a 2-stage pipeline with matched syncs.
module bouncing_square_painter #(
    parameter int COORD_BITS  = 10,
    parameter int COLOUR_BITS = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SQ_SIZE     = 32
) (
    input  logic                      i_clk_pxl,
    input  logic                      i_reset,
    bouncing_square_painter_if.slave  bus
);
    localparam int CW = COORD_BITS + 1;
    localparam logic [CW-1:0] LIM_X = CW'(H_ACTIVE - SQ_SIZE);
    localparam logic [CW-1:0] LIM_Y = CW'(V_ACTIVE - SQ_SIZE);
    localparam logic [CW-1:0] SQ    = CW'(SQ_SIZE);

    logic [CW-1:0] r_x, r_y;
    logic          r_dx_neg, r_dy_neg;
    logic [2:0]    r_ci;
    logic [7:0]    r_bounce_count;
    logic          r_corner;

    logic          r_s1_inside, r_s1_de, r_s1_hs, r_s1_vs;
    logic [2:0]    r_s1_ci;
    logic [COLOUR_BITS-1:0] r_red, r_green, r_blue;
    logic          r_s2_de, r_s2_hs, r_s2_vs;

    logic [CW-1:0] w_step, w_x_nxt, w_y_nxt, w_sx, w_sy;
    logic          w_dx_neg_nxt, w_dy_neg_nxt, w_bx, w_by, w_update, w_inside;
    logic [23:0]   w_pal, w_pix;

    assign w_update = bus.i_nf & ~bus.i_pause;
    assign w_step   = CW'(bus.i_speed) + CW'(1);
    assign w_sx     = CW'(bus.i_sx);
    assign w_sy     = CW'(bus.i_sy);

    always_comb begin
        w_x_nxt      = r_x;
        w_dx_neg_nxt = r_dx_neg;
        w_bx         = 1'b0;
        if (!r_dx_neg) begin
            if (r_x + w_step >= LIM_X) begin
                w_x_nxt      = LIM_X;
                w_dx_neg_nxt = 1'b1;
                w_bx         = 1'b1;
            end else begin
                w_x_nxt = r_x + w_step;
            end
        end else if (r_x <= w_step) begin
            w_x_nxt      = '0;
            w_dx_neg_nxt = 1'b0;
            w_bx         = 1'b1;
        end else begin
            w_x_nxt = r_x - w_step;
        end
    end

    always_comb begin
        w_y_nxt      = r_y;
        w_dy_neg_nxt = r_dy_neg;
        w_by         = 1'b0;
        if (!r_dy_neg) begin
            if (r_y + w_step >= LIM_Y) begin
                w_y_nxt      = LIM_Y;
                w_dy_neg_nxt = 1'b1;
                w_by         = 1'b1;
            end else begin
                w_y_nxt = r_y + w_step;
            end
        end else if (r_y <= w_step) begin
            w_y_nxt      = '0;
            w_dy_neg_nxt = 1'b0;
            w_by         = 1'b1;
        end else begin
            w_y_nxt = r_y - w_step;
        end
    end

    // A simultaneous X and Y bounce is a single event: one colour step, one count, corner pulse.
    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            r_x            <= '0;
            r_y            <= '0;
            r_dx_neg       <= 1'b0;
            r_dy_neg       <= 1'b0;
            r_ci           <= '0;
            r_bounce_count <= '0;
            r_corner       <= 1'b0;
        end else begin
            r_corner <= w_update & w_bx & w_by;
            if (w_update) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_dx_neg <= w_dx_neg_nxt;
                r_dy_neg <= w_dy_neg_nxt;
                if (w_bx | w_by) begin
                    r_ci           <= r_ci + 3'd1;
                    r_bounce_count <= r_bounce_count + 8'd1;
                end
            end
        end
    end

    assign w_inside = (w_sx >= r_x) && (w_sx < r_x + SQ) &&
                      (w_sy >= r_y) && (w_sy < r_y + SQ);

    always_comb begin
        w_pal = 24'hFFFFFF;
        case (r_s1_ci)
            3'd0: w_pal = 24'hFFFFFF;
            3'd1: w_pal = 24'hFF0000;
            3'd2: w_pal = 24'h00FF00;
            3'd3: w_pal = 24'h0000FF;
            3'd4: w_pal = 24'hFFFF00;
            3'd5: w_pal = 24'h00FFFF;
            3'd6: w_pal = 24'hFF00FF;
            3'd7: w_pal = 24'hFF8000;
            default: w_pal = 24'hFFFFFF;
        endcase
    end

    assign w_pix = !r_s1_de ? 24'h000000 : (r_s1_inside ? w_pal : 24'h00008B);

    // Colour index travels with the pixel so a mid-pipeline update cannot tear it.
    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            r_s1_inside <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_ci     <= '0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_s2_de     <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_vs     <= 1'b0;
        end else begin
            r_s1_inside <= w_inside;
            r_s1_de     <= bus.i_de;
            r_s1_hs     <= bus.i_hsync;
            r_s1_vs     <= bus.i_vsync;
            r_s1_ci     <= r_ci;
            r_red       <= COLOUR_BITS'(w_pix[23:16]);
            r_green     <= COLOUR_BITS'(w_pix[15:8]);
            r_blue      <= COLOUR_BITS'(w_pix[7:0]);
            r_s2_de     <= r_s1_de;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
        end
    end

    assign bus.o_red          = r_red;
    assign bus.o_green        = r_green;
    assign bus.o_blue         = r_blue;
    assign bus.o_hsync        = r_s2_hs;
    assign bus.o_vsync        = r_s2_vs;
    assign bus.o_de           = r_s2_de;
    assign bus.o_bounce_count = r_bounce_count;
    assign bus.o_corner       = r_corner;
endmodule
